enemy_wave_scheduler: RTL and testbench
=======================================

// Module: enemy_wave_scheduler
// PURPOSE
// - Owns up to NUM_SLOTS enemy-plane instances of the VGA shooter.
// - Decides when and where each enemy spawns, advances it down the screen on move ticks and
//   handles hits and explosions. It also counts score and escapes.
// - Per-slot position and enable drive the enemy renderer/judge; hit reports arrive from the
//   collision logic.
// PARAMETERS
// - NUM_SLOTS       4    number of enemy slots (2..8)
// - SPAWN_INTERVAL  64   move ticks between spawn attempts (>=1)
// - SPEED           2    pixels added to y per move tick
// - Y_BOTTOM        479  last visible row; y beyond this means escaped
// - X_MIN           32   left offset added to random x
// - EXPLODE_TICKS   8    move ticks a slot stays in EXPLODE
// - MAX_ESCAPE      5    escapes that end the game
// PORTS
// - clk        in   1            system clock (only clock)
// - rst        in   1            asynchronous, active-high reset
// - move_tick  in   1            1-cycle enable pulse in clk domain, one per motion step
// - start      in   1            level/pulse: leave IDLE or HALT and begin a new wave
// - hit_valid  in   1            collision report strobe
// - hit_slot   in   SW           slot index hit; SW = $clog2(NUM_SLOTS)
// - enemy_x    out  10*NUM_SLOTS packed x per slot, slot i at [10i+9:10i]
// - enemy_y    out  10*NUM_SLOTS packed y per slot
// - enemy_en   out  NUM_SLOTS    slot ACTIVE (draw plane, collide)
// - exploding  out  NUM_SLOTS    slot in EXPLODE (draw blast, no collision)
// - score      out  16           hits, saturates at 16'hFFFF
// - escapes    out  3            escaped enemies this game
// - game_over  out  1            high in HALT
// BEHAVIOUR
// - Reset (async, any time): all outputs 0; slots FREE; FSM IDLE; LFSR = 10'h2A5; spawn counter 0.
// - Game FSM transitions:
//   - IDLE -(start)-> RUN.
//   - RUN -(escapes==MAX_ESCAPE)-> HALT.
//   - HALT -(start)-> RUN, with slots, score, escapes and spawn counter cleared that cycle.
// - IDLE and HALT freeze everything. move_tick and hit_valid are ignored there.
// - LFSR: 10-bit Fibonacci, taps x^10+x^7+1, steps every clk in RUN.
// - Slot FSM: FREE -> ACTIVE (spawn) -> FREE (escape) or EXPLODE (hit) -> FREE after EXPLODE_TICKS ticks.
// - Spawn counter increments on move_tick in RUN.
//   - At SPAWN_INTERVAL-1 on a tick: spawn into the lowest-index FREE slot and wrap to 0.
//   - Spawned slot gets x = X_MIN + lfsr[8:0] and y = 0.
//   - No FREE slot: the counter holds at SPAWN_INTERVAL-1 and retries on every tick.
// - Free vector is sampled at cycle start. A slot freed this cycle cannot be re-spawned this cycle.
// - Move: on move_tick each ACTIVE slot does y <= y+SPEED (11-bit sum).
//   - If the sum > Y_BOTTOM, the slot goes FREE, its y is kept, and escapes increments.
//   - Simultaneous escapes in one tick all count; escapes saturates at MAX_ESCAPE.
// - Hit: hit_valid with hit_slot ACTIVE -> EXPLODE next cycle, score+1, y frozen.
//   - Hit on a FREE/EXPLODE slot, or on an index >= NUM_SLOTS, is ignored.
// - Simultaneous hit and move/escape on the same slot: hit wins (no y update, no escape count).
// - EXPLODE timer counts move ticks. The slot becomes FREE on the tick where timer == EXPLODE_TICKS-1.
// - Latency: all outputs registered; an effect shows one clk after the causing tick/strobe.
// - enemy_en and exploding are never both high for one slot.
// STRUCTURE
// - Package enemy_pkg holds:
//   - slot_state_t {FREE, ACTIVE, EXPLODE};
//   - game_state_t {IDLE, RUN, HALT};
//   - SCREEN_W=640, SCREEN_H=480, LFSR_SEED, LFSR taps.
// - Sub-module enemy_slot: one per slot via generate.
//   - Contains the state, x/y, explode timer, spawn/hit/tick inputs and an escape pulse out.
// - Top level holds the game FSM, LFSR, spawn counter, lowest-free priority encoder, score and escapes.
// TESTING
// - Reset mid-RUN with 3 slots ACTIVE -> all outputs 0 in the same cycle; slots FREE; needs start again.
// - start, SPAWN_INTERVAL=4, ticks every 10 clk -> slot0 spawns on tick 4 (y=0, x=X_MIN+lfsr[8:0]),
//   then slot1 on tick 8.
// - ACTIVE slot at y=476, SPEED=2:
//   - tick -> y=478;
//   - next tick -> slot FREE, escapes=1, y stays 478.
// - hit_valid with hit_slot=1 in the same cycle as a move_tick -> slot1 EXPLODE with y unchanged,
//   score=1. After 8 ticks the slot is FREE.
// - All 4 slots ACTIVE at spawn time -> no spawn; counter holds. The first tick after a slot frees
//   spawns into it.
// - 5th escape -> game_over=1, ticks ignored; start -> score=0, escapes=0, RUN.

Source files
------------

// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy wave scheduler and its slots.
package enemy_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    ACTIVE  = 2'd1,
    EXPLODE = 2'd2
  } slot_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } game_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [9:0] LFSR_SEED = 10'h2A5;
  // Feedback taps for x^10 + x^7 + 1 (bit indices of the 10-bit register)
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;

  // One Fibonacci step: shift left, feed the tap XOR into bit 0
  function automatic logic [9:0] lfsr_next(input logic [9:0] v);
    return {v[8:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/enemy_slot.sv
// One enemy plane: FREE/ACTIVE/EXPLODE state, position and explode timer.
// Escape is reported combinationally so the parent counts it on the same edge.
module enemy_slot
  import enemy_pkg::*;
#(
  parameter int SPEED         = 2,
  parameter int Y_BOTTOM      = 479,
  parameter int EXPLODE_TICKS = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_run,
  input  logic       i_tick,
  input  logic       i_spawn,
  input  logic [9:0] i_spawn_x,
  input  logic       i_hit,
  output logic       o_free,
  output logic       o_en,
  output logic       o_exploding,
  output logic       o_escape,
  output logic [9:0] o_x,
  output logic [9:0] o_y
);

  localparam int TW = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS) : 1;

  slot_state_t   r_state;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [TW-1:0] r_timer;
  logic          r_en;
  logic          r_exploding;

  logic [10:0]   w_sum;
  logic          w_escape;

  // 11-bit sum so a move past row 1023 can never wrap back on screen
  assign w_sum    = {1'b0, r_y} + 11'(SPEED);
  // A hit in the same cycle takes priority, so it suppresses the escape
  assign w_escape = i_run && i_tick && !i_hit && (r_state == ACTIVE) && (w_sum > 11'(Y_BOTTOM));

  assign o_free      = (r_state == FREE);
  assign o_en        = r_en;
  assign o_exploding = r_exploding;
  assign o_escape    = w_escape;
  assign o_x         = r_x;
  assign o_y         = r_y;

  // Slot FSM with registered enable/explode flags; frozen outside RUN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= FREE;
      r_x         <= '0;
      r_y         <= '0;
      r_timer     <= '0;
      r_en        <= 1'b0;
      r_exploding <= 1'b0;
    end else if (i_clear) begin
      r_state     <= FREE;
      r_x         <= '0;
      r_y         <= '0;
      r_timer     <= '0;
      r_en        <= 1'b0;
      r_exploding <= 1'b0;
    end else if (i_run) begin
      unique case (r_state)
        FREE: begin
          if (i_spawn) begin
            r_state <= ACTIVE;
            r_x     <= i_spawn_x;
            r_y     <= '0;
            r_en    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (i_hit) begin
            r_state     <= EXPLODE;
            r_timer     <= '0;
            r_en        <= 1'b0;
            r_exploding <= 1'b1;
          end else if (i_tick) begin
            if (w_escape) begin
              // y is left at its last visible value
              r_state <= FREE;
              r_en    <= 1'b0;
            end else begin
              r_y <= w_sum[9:0];
            end
          end
        end
        EXPLODE: begin
          if (i_tick) begin
            if (r_timer == TW'(EXPLODE_TICKS - 1)) begin
              r_state     <= FREE;
              r_exploding <= 1'b0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= FREE;
          r_en        <= 1'b0;
          r_exploding <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Enemy wave scheduler: game FSM, spawn pacing, random x, score and escape tally.
module enemy_wave_scheduler
  import enemy_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int SPAWN_INTERVAL = 64,
  parameter int SPEED          = 2,
  parameter int Y_BOTTOM       = SCREEN_H - 1,
  parameter int X_MIN          = 32,
  parameter int EXPLODE_TICKS  = 8,
  parameter int MAX_ESCAPE     = 5,
  localparam int SW            = $clog2(NUM_SLOTS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_move_tick,
  input  logic                    i_start,
  input  logic                    i_hit_valid,
  input  logic [SW-1:0]           i_hit_slot,
  output logic [10*NUM_SLOTS-1:0] o_enemy_x,
  output logic [10*NUM_SLOTS-1:0] o_enemy_y,
  output logic [NUM_SLOTS-1:0]    o_enemy_en,
  output logic [NUM_SLOTS-1:0]    o_exploding,
  output logic [15:0]             o_score,
  output logic [2:0]              o_escapes,
  output logic                    o_game_over
);

  localparam int CW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

  game_state_t          r_state;
  logic                 r_game_over;
  logic [9:0]           r_lfsr;
  logic [CW-1:0]        r_spawn_cnt;
  logic [15:0]          r_score;
  logic [2:0]           r_escapes;

  logic                 w_run;
  logic                 w_begin;
  logic                 w_spawn_try;
  logic                 w_hit_ok;
  logic [NUM_SLOTS-1:0] w_free;
  logic [NUM_SLOTS-1:0] w_hit;
  logic [NUM_SLOTS-1:0] w_escape;
  logic [NUM_SLOTS-1:0] w_spawn;
  logic [9:0]           w_spawn_x;
  logic [3:0]           w_esc_cnt;
  logic [4:0]           w_esc_sum;

  assign w_run       = (r_state == RUN);
  // Leaving IDLE or HALT starts a fresh wave
  assign w_begin     = i_start && (r_state != RUN);
  assign w_spawn_try = w_run && i_move_tick && (r_spawn_cnt == CW'(SPAWN_INTERVAL - 1));
  // Lowest-index free slot as a one-hot; w_free reflects state at cycle start
  assign w_spawn     = w_spawn_try ? (w_free & (~w_free + NUM_SLOTS'(1))) : '0;
  assign w_spawn_x   = 10'(X_MIN) + {1'b0, r_lfsr[8:0]};
  assign w_hit_ok    = |(w_hit & o_enemy_en);
  assign w_esc_sum   = 5'(r_escapes) + 5'(w_esc_cnt);

  assign o_score     = r_score;
  assign o_escapes   = r_escapes;
  assign o_game_over = r_game_over;

  // Count how many slots escape on this tick; several may leave together
  always_comb begin
    w_esc_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_esc_cnt = w_esc_cnt + 4'(w_escape[i]);
    end
  end

  // Game FSM: IDLE/HALT wait for start, RUN halts once the escape limit is reached
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_game_over <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, HALT: begin
          if (i_start) begin
            r_state     <= RUN;
            r_game_over <= 1'b0;
          end
        end
        RUN: begin
          if (r_escapes == 3'(MAX_ESCAPE)) begin
            r_state     <= HALT;
            r_game_over <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  // Random source for spawn x, advancing every clock while running
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_run) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // Spawn pacing: wrap after a successful spawn, hold at the top while all slots are busy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_spawn_cnt <= '0;
    end else if (w_begin) begin
      r_spawn_cnt <= '0;
    end else if (w_run && i_move_tick) begin
      if (w_spawn_try) begin
        if (|w_free) begin
          r_spawn_cnt <= '0;
        end
      end else begin
        r_spawn_cnt <= r_spawn_cnt + 1'b1;
      end
    end
  end

  // Score and escape tally, both saturating
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_score   <= '0;
      r_escapes <= '0;
    end else if (w_begin) begin
      r_score   <= '0;
      r_escapes <= '0;
    end else if (w_run) begin
      if (w_hit_ok && (r_score != 16'hFFFF)) begin
        r_score <= r_score + 16'd1;
      end
      if (w_esc_sum > 5'(MAX_ESCAPE)) begin
        r_escapes <= 3'(MAX_ESCAPE);
      end else begin
        r_escapes <= w_esc_sum[2:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      // Out-of-range hit indices match no slot and are dropped naturally
      assign w_hit[gi] = w_run && i_hit_valid && (i_hit_slot == SW'(gi));

      enemy_slot #(
        .SPEED         (SPEED),
        .Y_BOTTOM      (Y_BOTTOM),
        .EXPLODE_TICKS (EXPLODE_TICKS)
      ) u_slot (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_begin),
        .i_run       (w_run),
        .i_tick      (i_move_tick),
        .i_spawn     (w_spawn[gi]),
        .i_spawn_x   (w_spawn_x),
        .i_hit       (w_hit[gi]),
        .o_free      (w_free[gi]),
        .o_en        (o_enemy_en[gi]),
        .o_exploding (o_exploding[gi]),
        .o_escape    (w_escape[gi]),
        .o_x         (o_enemy_x[10*gi +: 10]),
        .o_y         (o_enemy_y[10*gi +: 10])
      );
    end
  endgenerate

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Scoreboard bench for enemy_wave_scheduler with SPAWN_INTERVAL=4.
module tb_enemy_wave_scheduler;

  localparam int NS   = 4;
  localparam int SI   = 4;
  localparam int XMIN = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          move_tick = 1'b0;
  logic          start = 1'b0;
  logic          hit_valid = 1'b0;
  logic [1:0]    hit_slot = 2'd0;
  logic [39:0]   enemy_x;
  logic [39:0]   enemy_y;
  logic [NS-1:0] enemy_en;
  logic [NS-1:0] exploding;
  logic [15:0]   score;
  logic [2:0]    escapes;
  logic          game_over;

  always #5 clk = ~clk;

  enemy_wave_scheduler #(
    .NUM_SLOTS      (NS),
    .SPAWN_INTERVAL (SI),
    .SPEED          (2),
    .Y_BOTTOM       (479),
    .X_MIN          (XMIN),
    .EXPLODE_TICKS  (8),
    .MAX_ESCAPE     (5)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_move_tick (move_tick),
    .i_start     (start),
    .i_hit_valid (hit_valid),
    .i_hit_slot  (hit_slot),
    .o_enemy_x   (enemy_x),
    .o_enemy_y   (enemy_y),
    .o_enemy_en  (enemy_en),
    .o_exploding (exploding),
    .o_score     (score),
    .o_escapes   (escapes),
    .o_game_over (game_over)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] en;
    logic [3:0] ex;
    int         sc;
    int         es;
    bit         go;
    int         slot;
    int         y;
    int         x;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cur_cyc = 0;

  // Reference x^10+x^7+1 generator, running from the edge that accepts start
  logic [9:0] m_lfsr;
  bit         m_run;

  function automatic logic [9:0] ref_step(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 10'h2A5;
      m_run  <= 1'b0;
    end else begin
      if (m_run) m_lfsr <= ref_step(m_lfsr);
      if (start) m_run <= 1'b1;
    end
  end

  function automatic int xexp();
    return XMIN + int'(m_lfsr[8:0]);
  endfunction

  // Monitor: after every edge, compare all expectations due on this snapshot
  always @(posedge clk) begin
    exp_t e;
    bit   ok;
    int   ay;
    int   ax;
    #1;
    cur_cyc++;
    while (q.size() > 0 && q[0].cyc <= cur_cyc) begin
      e  = q.pop_front();
      ay = (e.slot >= 0) ? int'(enemy_y[10*e.slot +: 10]) : 0;
      ax = (e.slot >= 0) ? int'(enemy_x[10*e.slot +: 10]) : 0;
      ok = (e.cyc == cur_cyc) && (enemy_en == e.en) && (exploding == e.ex) &&
           (int'(score) == e.sc) && (int'(escapes) == e.es) && (game_over == e.go);
      if (e.slot >= 0 && ay != e.y) ok = 1'b0;
      if (e.slot >= 0 && e.x >= 0 && ax != e.x) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s: got en=%b ex=%b score=%0d esc=%0d go=%b y=%0d x=%0d, want en=%b ex=%b score=%0d esc=%0d go=%b y=%0d x=%0d (slot %0d)",
                 e.name, enemy_en, exploding, score, escapes, game_over, ay, ax,
                 e.en, e.ex, e.sc, e.es, e.go, e.y, e.x, e.slot);
      end else begin
        $display("[cyc %0d] %s ok: en=%b ex=%b score=%0d esc=%0d go=%b", cur_cyc, e.name,
                 enemy_en, exploding, score, escapes, game_over);
      end
    end
  end

  // Queue the expected outputs for the snapshot 'off' edges from now (call at negedge)
  task automatic expect_at(input int off, input string nm, input logic [3:0] en,
                           input logic [3:0] ex, input int sc, input int es, input bit go,
                           input int slot = -1, input int y = 0, input int x = -1);
    exp_t e;
    e.cyc = cur_cyc + off; e.name = nm; e.en = en; e.ex = ex; e.sc = sc; e.es = es;
    e.go = go; e.slot = slot; e.y = y; e.x = x;
    q.push_back(e);
  endtask

  task automatic cyc1(input bit tk, input bit hv, input logic [1:0] hs, input bit st);
    move_tick = tk; hit_valid = hv; hit_slot = hs; start = st;
    @(negedge clk);
    move_tick = 1'b0; hit_valid = 1'b0; start = 1'b0;
  endtask

  task automatic tick();
    cyc1(1'b1, 1'b0, 2'd0, 1'b0);
    cyc1(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    @(negedge clk);
    expect_at(1, "reset_state", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    cyc1(0, 0, 0, 0);
    rst = 1'b0;

    expect_at(1, "idle_tick_ignored", 4'b0000, 4'b0000, 0, 0, 0);
    tick();
    expect_at(1, "start_run", 4'b0000, 4'b0000, 0, 0, 0);
    cyc1(0, 0, 0, 1);

    ticks(2);
    expect_at(1, "tick3_no_spawn", 4'b0000, 4'b0000, 0, 0, 0);
    tick();
    expect_at(1, "spawn_slot0_t4", 4'b0001, 4'b0000, 0, 0, 0, 0, 0, xexp());
    tick();
    ticks(3);
    expect_at(1, "spawn_slot1_t8", 4'b0011, 4'b0000, 0, 0, 0, 1, 0, xexp());
    expect_at(1, "slot0_y8", 4'b0011, 4'b0000, 0, 0, 0, 0, 8);
    tick();

    expect_at(1, "hit_free_ignored", 4'b0011, 4'b0000, 0, 0, 0);
    cyc1(0, 1, 2'd3, 0);

    expect_at(1, "hit_with_tick", 4'b0001, 4'b0010, 1, 0, 0, 1, 0);
    expect_at(1, "slot0_moves_y10", 4'b0001, 4'b0010, 1, 0, 0, 0, 10);
    cyc1(1, 1, 2'd1, 0);
    cyc1(0, 0, 0, 0);
    expect_at(1, "hit_explode_ignored", 4'b0001, 4'b0010, 1, 0, 0, 1, 0);
    cyc1(0, 1, 2'd1, 0);

    ticks(6);
    expect_at(1, "explode_7_ticks", 4'b1101, 4'b0010, 1, 0, 0, 1, 0);
    tick();
    expect_at(1, "explode_done_8", 4'b1101, 4'b0000, 1, 0, 0, 1, 0);
    tick();
    ticks(2);
    expect_at(1, "respawn_slot1_t20", 4'b1111, 4'b0000, 1, 0, 0, 1, 0, xexp());
    tick();
    ticks(3);
    expect_at(1, "all_full_hold", 4'b1111, 4'b0000, 1, 0, 0, 0, 40);
    tick();

    ticks(218);
    expect_at(1, "y476_to_478", 4'b1111, 4'b0000, 1, 0, 0, 0, 478);
    tick();
    expect_at(1, "escape1_y_kept", 4'b1110, 4'b0000, 1, 1, 0, 0, 478);
    tick();
    expect_at(1, "respawn_after_free", 4'b1111, 4'b0000, 1, 1, 0, 0, 0, xexp());
    tick();

    ticks(14);
    expect_at(1, "escape4", 4'b1101, 4'b0000, 1, 4, 0);
    tick();
    ticks(224);
    expect_at(1, "escape5", 4'b1110, 4'b0000, 1, 5, 0, 1, 448);
    expect_at(2, "game_over", 4'b1110, 4'b0000, 1, 5, 1, 1, 448);
    tick();

    expect_at(1, "halt_tick_ignored", 4'b1110, 4'b0000, 1, 5, 1, 1, 448);
    tick();
    expect_at(1, "halt_hit_ignored", 4'b1110, 4'b0000, 1, 5, 1, 1, 448);
    cyc1(0, 1, 2'd1, 0);

    expect_at(1, "restart_cleared", 4'b0000, 4'b0000, 0, 0, 0);
    cyc1(0, 0, 0, 1);
    ticks(3);
    expect_at(1, "restart_spawn_t4", 4'b0001, 4'b0000, 0, 0, 0, 0, 0);
    tick();
    ticks(7);
    expect_at(1, "three_active", 4'b0111, 4'b0000, 0, 0, 0, 2, 0);
    tick();

    // Reset pulse that lies entirely between two rising edges
    expect_at(2, "async_reset", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_at(1, "post_reset_tick_ignored", 4'b0000, 4'b0000, 0, 0, 0, 1, 0, 0);
    tick();
    cyc1(0, 0, 0, 1);
    ticks(3);
    expect_at(1, "reseeded_spawn", 4'b0001, 4'b0000, 0, 0, 0, 0, 0, xexp());
    tick();

    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
